// File: rtl/reg_xfer_ctrl_pkg.sv
// Shared types for the register-transfer controller: op encodings,
// FSM state encoding and default widths.
package reg_xfer_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_SEL_W  = 2;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_MVI = 2'b01,
    OP_RDR = 2'b10,
    OP_SWP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_CAP_A,
    S_RD_B,
    S_CAP_B,
    S_WR_A,
    S_WR_B,
    S_DONE
  } state_e;

endpackage

// File: rtl/reg_xfer_ctrl_if.sv
// Command/response port (decoder side) and register-bank port (bank side).
interface reg_cmd_if
  import reg_xfer_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [SEL_W-1:0]  cmd_dst;
  logic [SEL_W-1:0]  cmd_src;
  logic [DATA_W-1:0] cmd_imm;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
                  input  cmd_ready, rsp_valid, rsp_data, busy);
  modport slave  (input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
                  output cmd_ready, rsp_valid, rsp_data, busy);
endinterface

interface reg_bank_if
  import reg_xfer_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
);
  logic [SEL_W-1:0]  bank_select;
  logic              bank_rd;
  logic              bank_wr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_rdata;

  modport master (output bank_select, bank_rd, bank_wr, bank_wdata,
                  input  bank_rdata);
  modport slave  (input  bank_select, bank_rd, bank_wr, bank_wdata,
                  output bank_rdata);
endinterface

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer controller: sequences MOV/MVI/RDR/SWP into bank
// read, capture and write cycles, one command at a time.
module reg_xfer_ctrl
  import reg_xfer_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic       reg_clk,
  input  logic       reg_rst,
  reg_cmd_if.slave   cmd,
  reg_bank_if.master bank
);

  state_e            state_q;
  op_e               op_q;
  logic [SEL_W-1:0]  dst_q, src_q, sel_q;
  logic [DATA_W-1:0] imm_q, tmp_a_q, tmp_b_q, rsp_data_q;
  logic              rd_q, wr_q, rsp_valid_q, ready_q;
  logic [DATA_W-1:0] wdata;

  // Write data is a pure decode of registered state; only the WR states
  // put anything on the bus.
  always_comb begin
    wdata = '0;
    case (state_q)
      S_WR_A:  wdata = (op_q == OP_MVI) ? imm_q :
                       (op_q == OP_SWP) ? tmp_b_q : tmp_a_q;
      S_WR_B:  wdata = tmp_a_q;
      default: wdata = '0;
    endcase
  end

  // Sequencer: state, latched command, temporaries and registered outputs.
  // Strobes default low so each RD/WR state strobes for exactly one cycle.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MOV;
      dst_q       <= '0;
      src_q       <= '0;
      sel_q       <= '0;
      imm_q       <= '0;
      tmp_a_q     <= '0;
      tmp_b_q     <= '0;
      rsp_data_q  <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd.cmd_valid) begin
          op_q    <= cmd.cmd_op;
          dst_q   <= cmd.cmd_dst;
          src_q   <= cmd.cmd_src;
          imm_q   <= cmd.cmd_imm;
          ready_q <= 1'b0;
          if (cmd.cmd_op == OP_MVI) begin
            state_q <= S_WR_A;
            wr_q    <= 1'b1;
            sel_q   <= cmd.cmd_dst;
          end else begin
            // SWP reads r1 (dst) first; MOV/RDR read the source.
            state_q <= S_RD_A;
            rd_q    <= 1'b1;
            sel_q   <= (cmd.cmd_op == OP_SWP) ? cmd.cmd_dst : cmd.cmd_src;
          end
        end
        S_RD_A: state_q <= S_CAP_A;
        S_CAP_A: begin
          tmp_a_q <= bank.bank_rdata;
          case (op_q)
            OP_RDR: begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= bank.bank_rdata;
            end
            OP_SWP: begin
              state_q <= S_RD_B;
              rd_q    <= 1'b1;
              sel_q   <= src_q;
            end
            default: begin
              state_q <= S_WR_A;
              wr_q    <= 1'b1;
              sel_q   <= dst_q;
            end
          endcase
        end
        S_RD_B: state_q <= S_CAP_B;
        S_CAP_B: begin
          tmp_b_q <= bank.bank_rdata;
          state_q <= S_WR_A;
          wr_q    <= 1'b1;
          sel_q   <= dst_q;
        end
        S_WR_A: begin
          if (op_q == OP_SWP) begin
            state_q <= S_WR_B;
            wr_q    <= 1'b1;
            sel_q   <= src_q;
          end else begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= wdata;
          end
        end
        S_WR_B: begin
          state_q     <= S_DONE;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= wdata;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready   = ready_q;
  assign cmd.busy        = !ready_q;
  assign cmd.rsp_valid   = rsp_valid_q;
  assign cmd.rsp_data    = rsp_data_q;
  assign bank.bank_select = sel_q;
  assign bank.bank_rd     = rd_q;
  assign bank.bank_wr     = wr_q;
  assign bank.bank_wdata  = wdata;

endmodule

// File: doc/reg_xfer_ctrl.md
Name: reg_xfer_ctrl

Overview:
- Command-driven initiator for the 4-entry, 8-bit register bank. It is the master side of the bank's select/rd/wr/data port.
- Executes register-level micro-operations: move, load-immediate, read-out and swap.
- Turns each operation into correctly timed bank read and write cycles.
- Sits between the instruction decoder (command side) and the register bank (bank side).

Parameters:
- DATA_W, 8, register and data width.
- SEL_W, 2, register select width (2**SEL_W registers).

Ports:
- reg_clk  input  1  clock; all state updates on rising edge.
- reg_rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block accepts a command this cycle.
- cmd_op  input  2  00 MOV, 01 MVI, 10 RDR, 11 SWP.
- cmd_dst  input  SEL_W  destination register (r1 for SWP).
- cmd_src  input  SEL_W  source register (r2 for SWP; read target for RDR).
- cmd_imm  input  DATA_W  immediate for MVI.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_data  output  DATA_W  RDR: value read; other ops: value last written.
- busy  output  1  high while a command is in progress.
- bank_select  output  SEL_W  register select to bank.
- bank_rd  output  1  bank read strobe.
- bank_wr  output  1  bank write strobe.
- bank_wdata  output  DATA_W  bank write data.
- bank_rdata  input  DATA_W  bank registered read data.

Behaviour:
- Reset:
  - All outputs 0, except cmd_ready=1.
  - State=IDLE; tmp_a=tmp_b=0.
  - Reset mid-operation aborts the operation: no further bank strobes and no rsp_valid.
- Bank timing: the bank samples select/rd/wr/wdata at the reg_clk edge. bank_rdata is valid the cycle after bank_rd is asserted and holds until the next read.
- Bank strobes: bank_rd and bank_wr are never high in the same cycle. Both are 0 in IDLE and DONE.
- Command handshake:
  - cmd_ready = (state==IDLE).
  - A command is accepted on cmd_valid & cmd_ready; cmd fields are latched at that edge.
  - busy = !cmd_ready.
- States: IDLE, RD_A, CAP_A, RD_B, CAP_B, WR_A, WR_B, DONE.
  - RD_x: drive bank_rd=1 with the select.
  - CAP_x: no strobe; tmp_x <= bank_rdata.
  - WR_x: drive bank_wr=1 with select and wdata.
- Sequences (the accept edge starts the first state):
  - MOV: RD_A(src) -> CAP_A -> WR_A(dst, tmp_a) -> DONE. 4 cycles after accept until the rsp_valid cycle.
  - MVI: WR_A(dst, cmd_imm) -> DONE.
  - RDR: RD_A(src) -> CAP_A -> DONE; rsp_data=tmp_a.
  - SWP: RD_A(dst) -> CAP_A -> RD_B(src) -> CAP_B -> WR_A(dst, tmp_b) -> WR_B(src, tmp_a) -> DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. rsp_data is registered and holds until the next DONE. No response back-pressure.
- Boundary cases:
  - MOV with dst==src: performs the read and the write; register unchanged.
  - SWP with dst==src: performs all cycles; register unchanged.
  - cmd_valid during busy: ignored, not queued. The requester must hold it until cmd_ready.
  - Back-to-back commands: the next accept is possible in the cycle after DONE.

Decomposition:
- Shared package holds:
  - op encodings (OP_MOV, OP_MVI, OP_RDR, OP_SWP);
  - FSM state enum;
  - DATA_W/SEL_W defaults.
- No sub-module is needed; datapath (tmp_a, tmp_b, rsp_data) and FSM live in one module.
- The bench pairs the block with the existing register bank.

Test Plan:
- Load and read: MVI r0=0x5A, then RDR r0 -> one bank_wr with select=0, wdata=0x5A; rsp_data=0x5A; rsp_valid 3 cycles after the RDR accept.
- MOV: MVI r2=0xC3, MOV r1<-r2 -> bank_rd on select=2, then two cycles later bank_wr on select=1 with wdata=0xC3; RDR r1 returns 0xC3.
- SWP: r0=0x11, r3=0xEE, SWP r0,r3 -> r0=0xEE, r3=0x11; rsp_valid exactly 7 cycles after accept; rd and wr never both high.
- Busy handling: issue MOV, hold cmd_valid with MVI r1=0x77 during busy -> cmd_ready=0 until after DONE; MVI is accepted once; exactly one r1 write.
- Reset mid-SWP: assert reg_rst in CAP_B (r0=0x11, r3=0xEE) -> outputs 0 immediately, cmd_ready=1 after release, no rsp_valid; registers keep 0x11/0xEE (no partial swap).
- Self-ops: SWP r2,r2 and MOV r2<-r2 with r2=0x3C -> r2 stays 0x3C; rsp_data=0x3C.
